// File: rtl/cond_branch_ctrl.sv
// cond_branch_ctrl
//   Sequences conditional execution and branch resolution. It holds the
//   architectural NZCV flag register and evaluates a 4-bit condition code
//   for each decode-stage request using a Req/Ack handshake. For a taken
//   branch it pulses PcSel once and holds Flush for FLUSH_CYCLES cycles.
//
//   Optional build macro: COND_FLAG_FWD_EN
//     When defined, a FlagWr in the EVAL cycle forwards {N_in,Z_in,C_in,V_in}
//     straight into that cycle's evaluation.
//
// Parameters
//   FLUSH_CYCLES : cycles Flush is held after a taken branch (1..15)
//   CNT_W        : flush counter width, 2**CNT_W > FLUSH_CYCLES
//
// Ports
//   Clk, Reset          : clock (rising edge), synchronous active-high reset
//   Req, Code, IsBranch : request, condition code, branch flag (sampled in IDLE)
//   FlagWr, N_in..V_in  : ALU flag write enable and flag values
//   Ack, CondPass       : one-cycle result pulse and condition outcome
//   PcSel, Flush        : branch target select pulse, pipeline squash
//   Busy                : FSM not in IDLE
//   Flags               : flag register {N,Z,C,V}
module cond_branch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req,
  input  logic [3:0] Code,
  input  logic       IsBranch,
  input  logic       FlagWr,
  input  logic       N_in,
  input  logic       Z_in,
  input  logic       C_in,
  input  logic       V_in,
  output logic       Ack,
  output logic       CondPass,
  output logic       PcSel,
  output logic       Flush,
  output logic       Busy,
  output logic [3:0] Flags
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       code_q;
  logic             isbr_q;
  logic [3:0]       eval_src;
  logic             pass;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      Flags  <= '0;
      code_q <= '0;
      isbr_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (FlagWr) begin
        Flags <= {N_in, Z_in, C_in, V_in};
      end
      if (state == S_IDLE && Req) begin
        code_q <= Code;
        isbr_q <= IsBranch;
      end
    end
  end

`ifdef COND_FLAG_FWD_EN
  assign eval_src = (state == S_EVAL && FlagWr) ? {N_in, Z_in, C_in, V_in} : Flags;
`else
  assign eval_src = Flags;
`endif

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = eval_src;
    pass = 1'b0;
    case (code_q)
      4'b0000: pass = z;
      4'b0001: pass = !z;
      4'b0010: pass = c;
      4'b0011: pass = !c;
      4'b0100: pass = n;
      4'b0101: pass = !n;
      4'b0110: pass = v;
      4'b0111: pass = !v;
      4'b1000: pass = c && !z;
      4'b1001: pass = !c || z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = !z && (n == v);
      4'b1101: pass = z || (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    Ack      = 1'b0;
    CondPass = 1'b0;
    PcSel    = 1'b0;
    Flush    = 1'b0;
    Busy     = 1'b1;
    case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Req) begin
          state_nx = S_EVAL;
        end
      end
      S_EVAL: begin
        Ack      = 1'b1;
        CondPass = pass;
        if (isbr_q && pass) begin
          state_nx = S_FLUSH;
          cnt_nx   = CNT_LOAD;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_FLUSH: begin
        Flush = 1'b1;
        // The counter is loaded with CNT_LOAD on entry and only counts down,
        // so it equals CNT_LOAD exactly in the first flush cycle.
        PcSel = (cnt == CNT_LOAD);
        if (cnt == '0) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        Busy     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cond_branch_ctrl.sv
// Testbench for cond_branch_ctrl: directed table, hand-written corner
// sequences and a randomized run against a transaction-level model.
module tb_cond_branch_ctrl;

`ifdef COND_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int F = 2;

  logic       Clk, Reset, Req, IsBranch, FlagWr;
  logic       N_in, Z_in, C_in, V_in;
  logic [3:0] Code;
  logic       Ack, CondPass, PcSel, Flush, Busy;
  logic [3:0] Flags;
  logic       Ack3, CondPass3, PcSel3, Flush3, Busy3;
  logic [3:0] Flags3;

  int n_chk  = 0;
  int n_fail = 0;

  cond_branch_ctrl #(.FLUSH_CYCLES(F), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Code(Code), .IsBranch(IsBranch),
    .FlagWr(FlagWr), .N_in(N_in), .Z_in(Z_in), .C_in(C_in), .V_in(V_in),
    .Ack(Ack), .CondPass(CondPass), .PcSel(PcSel), .Flush(Flush),
    .Busy(Busy), .Flags(Flags)
  );

  cond_branch_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut3 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Code(Code), .IsBranch(IsBranch),
    .FlagWr(FlagWr), .N_in(N_in), .Z_in(Z_in), .C_in(C_in), .V_in(V_in),
    .Ack(Ack3), .CondPass(CondPass3), .PcSel(PcSel3), .Flush(Flush3),
    .Busy(Busy3), .Flags(Flags3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Condition predicate pairs: odd codes are the inverse of the even code
  // below them; 1111 is never.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (cc == 4'b1111) return 1'b0;
    return r ^ cc[0];
  endfunction

  typedef struct {
    logic [3:0] code;
    logic [3:0] nzcv;
    logic       br;
    logic       pass;
  } vec_t;

  vec_t tbl[18];

  // Write flags, issue one request, check result and any flush window.
  task automatic apply(input vec_t v);
    FlagWr = 1'b1; {N_in, Z_in, C_in, V_in} = v.nzcv;
    tick;
    FlagWr = 1'b0;
    chk("tbl_flags", Flags, v.nzcv);
    Req = 1'b1; Code = v.code; IsBranch = v.br;
    tick;
    Req = 1'b0;
    chk("tbl_ack", {3'b0, Ack}, 4'h1);
    chk("tbl_pass", {3'b0, CondPass}, {3'b0, v.pass});
    tick;
    if (v.br && v.pass) begin
      chk("tbl_pcsel1", {3'b0, PcSel}, 4'h1);
      chk("tbl_flush1", {3'b0, Flush}, 4'h1);
      tick;
      chk("tbl_pcsel2", {3'b0, PcSel}, 4'h0);
      chk("tbl_flush2", {3'b0, Flush}, 4'h1);
      tick;
    end
    chk("tbl_end_flush", {3'b0, Flush}, 4'h0);
    chk("tbl_end_pcsel", {3'b0, PcSel}, 4'h0);
    chk("tbl_end_busy", {3'b0, Busy}, 4'h0);
    chk("tbl_end_ack", {3'b0, Ack}, 4'h0);
  endtask

  initial begin
    logic [4:0] e_ack, e_flush, e_busy;
    int  cyc, eval_cyc, flush_lo, flush_hi;
    logic [3:0] mflags, m_code, src;
    logic m_br, holding, e_a, e_p, e_f, e_s, e_b;

    tbl[0]  = '{4'b0000, 4'b0100, 1'b0, 1'b1};
    tbl[1]  = '{4'b0001, 4'b0100, 1'b0, 1'b0};
    tbl[2]  = '{4'b0010, 4'b0010, 1'b1, 1'b1};
    tbl[3]  = '{4'b0011, 4'b0010, 1'b0, 1'b0};
    tbl[4]  = '{4'b0100, 4'b1000, 1'b0, 1'b1};
    tbl[5]  = '{4'b0101, 4'b1000, 1'b1, 1'b0};
    tbl[6]  = '{4'b0110, 4'b0001, 1'b0, 1'b1};
    tbl[7]  = '{4'b0111, 4'b0000, 1'b0, 1'b1};
    tbl[8]  = '{4'b1000, 4'b0010, 1'b0, 1'b1};
    tbl[9]  = '{4'b1000, 4'b0110, 1'b1, 1'b0};
    tbl[10] = '{4'b1001, 4'b0010, 1'b1, 1'b0};
    tbl[11] = '{4'b1010, 4'b1001, 1'b0, 1'b1};
    tbl[12] = '{4'b1011, 4'b1000, 1'b1, 1'b1};
    tbl[13] = '{4'b1100, 4'b1001, 1'b1, 1'b1};
    tbl[14] = '{4'b1100, 4'b0101, 1'b0, 1'b0};
    tbl[15] = '{4'b1101, 4'b0100, 1'b0, 1'b1};
    tbl[16] = '{4'b1111, 4'b0010, 1'b1, 1'b0};
    tbl[17] = '{4'b1110, 4'b0010, 1'b1, 1'b1};

    Reset = 1'b1; Req = 1'b0; Code = '0; IsBranch = 1'b0; FlagWr = 1'b0;
    {N_in, Z_in, C_in, V_in} = 4'b0000;
    tick;
    tick;
    Reset = 1'b0;
    chk("rst_ack", {3'b0, Ack}, 4'h0);
    chk("rst_pass", {3'b0, CondPass}, 4'h0);
    chk("rst_pcsel", {3'b0, PcSel}, 4'h0);
    chk("rst_flush", {3'b0, Flush}, 4'h0);
    chk("rst_busy", {3'b0, Busy}, 4'h0);
    chk("rst_flags", Flags, 4'h0);

    // Reset during the second flush cycle of a FLUSH_CYCLES=3 instance,
    // with a simultaneous FlagWr that must lose to reset.
    Req = 1'b1; Code = 4'b1110; IsBranch = 1'b1;
    tick;
    Req = 1'b0;
    chk("r3_ack", {3'b0, Ack3}, 4'h1);
    tick;
    chk("r3_pcsel", {3'b0, PcSel3}, 4'h1);
    tick;
    chk("r3_flush2", {3'b0, Flush3}, 4'h1);
    Reset = 1'b1; FlagWr = 1'b1; {N_in, Z_in, C_in, V_in} = 4'b1111;
    tick;
    Reset = 1'b0; FlagWr = 1'b0;
    chk("r3_flush_after_rst", {3'b0, Flush3}, 4'h0);
    chk("r3_busy_after_rst", {3'b0, Busy3}, 4'h0);
    chk("r3_flags_after_rst", Flags3, 4'h0);
    chk("r3_pcsel_after_rst", {3'b0, PcSel3}, 4'h0);
    Req = 1'b1; Code = 4'b1110; IsBranch = 1'b0;
    tick;
    Req = 1'b0;
    chk("r3_req_after_rst", {3'b0, Ack3}, 4'h1);
    chk("r3_pass_after_rst", {3'b0, CondPass3}, 4'h1);
    tick;
    chk("r3_idle", {3'b0, Busy3}, 4'h0);

    // Req held through a taken branch: re-sampled only once IDLE returns.
    Req = 1'b1; Code = 4'b1110; IsBranch = 1'b1;
    e_ack = 5'b10001; e_flush = 5'b01100; e_busy = 5'b11101;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_ack", {3'b0, Ack}, {3'b0, e_ack[4-i]});
      chk("hold_flush", {3'b0, Flush}, {3'b0, e_flush[4-i]});
      chk("hold_busy", {3'b0, Busy}, {3'b0, e_busy[4-i]});
    end
    Req = 1'b0;
    tick; tick; tick;
    chk("hold_idle", {3'b0, Busy}, 4'h0);

    for (int i = 0; i < 18; i++) apply(tbl[i]);

    // FlagWr in the EVAL cycle: visible only with forwarding built in.
    FlagWr = 1'b1; {N_in, Z_in, C_in, V_in} = 4'b0000;
    tick;
    FlagWr = 1'b0;
    Req = 1'b1; Code = 4'b0000; IsBranch = 1'b0;
    tick;
    Req = 1'b0;
    FlagWr = 1'b1; {N_in, Z_in, C_in, V_in} = 4'b0100;
    #1;
    chk("fwd_ack", {3'b0, Ack}, 4'h1);
    chk("fwd_pass", {3'b0, CondPass}, {3'b0, FWD});
    tick;
    FlagWr = 1'b0;
    chk("fwd_flags", Flags, 4'b0100);
    tick;

    // Randomized run against a transaction-level model.
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0; Req = 1'b0; FlagWr = 1'b0;
    cyc = 0; eval_cyc = -10; flush_lo = -10; flush_hi = -10;
    mflags = 4'b0000; m_code = '0; m_br = 1'b0; holding = 1'b0; e_p = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge Clk);
      if (!holding) begin
        if ($urandom_range(1, 0) == 1) begin
          Req = 1'b1; Code = 4'($urandom_range(15, 0)); IsBranch = 1'($urandom_range(1, 0));
          holding = 1'b1;
        end else begin
          Req = 1'b0;
        end
      end
      FlagWr = ($urandom_range(2, 0) == 0);
      {N_in, Z_in, C_in, V_in} = 4'($urandom_range(15, 0));
      #1;
      e_a = (cyc == eval_cyc);
      if (e_a) begin
        src = (FWD && FlagWr) ? {N_in, Z_in, C_in, V_in} : mflags;
        e_p = ref_cond(m_code, src);
        if (m_br && e_p) begin
          flush_lo = cyc + 1;
          flush_hi = cyc + F;
        end
      end
      e_f = (cyc >= flush_lo) && (cyc <= flush_hi);
      e_s = (cyc == flush_lo);
      e_b = e_a || e_f;
      chk("rnd_ack", {3'b0, Ack}, {3'b0, e_a});
      chk("rnd_pass", {3'b0, CondPass}, {3'b0, e_a && e_p});
      chk("rnd_pcsel", {3'b0, PcSel}, {3'b0, e_s});
      chk("rnd_flush", {3'b0, Flush}, {3'b0, e_f});
      chk("rnd_busy", {3'b0, Busy}, {3'b0, e_b});
      chk("rnd_flags", Flags, mflags);
      if (e_a) holding = 1'b0;
      if (FlagWr) mflags = {N_in, Z_in, C_in, V_in};
      if (!e_b && Req) begin
        eval_cyc = cyc + 1;
        m_code = Code;
        m_br = IsBranch;
      end
      cyc++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_branch_ctrl.md
Name: cond_branch_ctrl

Overview:
- Sequences conditional execution and branch resolution for the datapath.
- Owns the architectural NZCV flag register, which the ALU updates.
- Evaluates a 4-bit condition code for each requester transaction with a Req/Ack handshake.
- For taken branches, drives the PC-select and pipeline-flush window.
- Sits between the decode stage (requester) and the fetch/PC logic.

Parameters:
- FLUSH_CYCLES, 2, number of cycles Flush is held after a taken branch; legal range 1..15, any other value is illegal.
- CNT_W, 4, width of the flush counter; must satisfy 2^CNT_W > FLUSH_CYCLES.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  1  requester asks for a condition evaluation; sampled only in IDLE.
- Code  input  4  condition code, sampled with Req.
- IsBranch  input  1  transaction is a branch, sampled with Req.
- FlagWr  input  1  ALU flag write enable; the S bit is already qualified upstream.
- N_in, Z_in, C_in, V_in  input  1 each  flag values from the ALU.
- Ack  output  1  one-cycle pulse: CondPass is valid.
- CondPass  output  1  condition result; valid only while Ack=1.
- PcSel  output  1  one-cycle pulse selecting the branch target into the PC.
- Flush  output  1  squash the younger pipeline stages.
- Busy  output  1  high whenever the FSM is not in IDLE.
- Flags  output  4  flag register contents, ordered {N,Z,C,V}.

Behaviour:
- Reset (synchronous, active-high): at the next edge, state=IDLE, Flags=4'b0000, flush counter=0, latched Code/IsBranch cleared.
  - All outputs are 0 after that edge.
  - Reset overrides everything, including a transaction in flight and a simultaneous FlagWr.
- Flag register:
  - On any edge with FlagWr=1 and no Reset, Flags <= {N_in,Z_in,C_in,V_in}.
  - This applies in every state.
- Condition evaluation (combinational on the latched Code and the evaluation flag source):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111 NV: 0
- State IDLE:
  - Busy=0.
  - If Req=1 at an edge: latch Code and IsBranch, go to EVAL.
- State EVAL (exactly one cycle):
  - Ack=1; CondPass = evaluation result.
  - If latched IsBranch=1 and CondPass=1: next state FLUSH, counter <= FLUSH_CYCLES-1.
  - Otherwise: return to IDLE.
- State FLUSH:
  - Flush=1 every cycle; PcSel=1 in the first FLUSH cycle only.
  - Counter decrements each cycle; leave to IDLE on the edge where the counter is 0.
  - Flush is therefore high for exactly FLUSH_CYCLES cycles.
- Latency: Req sampled at edge t; Ack/CondPass are valid during the cycle after t.
  - Back-to-back non-branch requests give one Ack every 2 cycles.
  - A taken branch occupies 2+FLUSH_CYCLES cycles from the Req edge until IDLE is re-entered.
- Req is ignored while Busy=1. The requester holds Req until it sees Ack.
  - Consequence: a Req still asserted in the cycle Ack=1 is not sampled, because the state is EVAL, not IDLE.
  - It is sampled at the next IDLE edge.
- Flag hazard: without the optional feature, EVAL uses the registered Flags value.
  - A FlagWr in the EVAL cycle itself is not visible to that evaluation.
- Ack, CondPass, PcSel and Flush are never X. CondPass=0 whenever Ack=0.

Optional Feature:
- Macro: COND_FLAG_FWD_EN.
- Defined: in EVAL, if FlagWr=1 in the same cycle, evaluation uses {N_in,Z_in,C_in,V_in} instead of Flags (same-cycle forwarding). The flag register update is unchanged.
- Undefined: evaluation always uses the registered Flags; no forwarding mux is built.

Test Plan:
- Reset mid-FLUSH (FLUSH_CYCLES=3, Reset asserted in the 2nd flush cycle) -> next edge: Flush=0, Busy=0, Flags=0000, PcSel=0; a Req on the following edge is accepted normally.
- FlagWr with NZCV=0100, then Req Code=0000 (EQ), IsBranch=0 -> Ack=1, CondPass=1 one cycle after Req; no Flush; Busy back to 0 after Ack.
- Flags=1001 (N=1,V=1), Req Code=1100 (GT), IsBranch=1 -> CondPass=1, then PcSel=1 for 1 cycle and Flush=1 for exactly FLUSH_CYCLES=2 cycles.
- Flags=0010, Req Code=1001 (LS), IsBranch=1 -> CondPass=0, no PcSel, no Flush; then Code=1111 -> CondPass=0; then Code=1110 -> CondPass=1.
- Flags=0000; FlagWr with NZCV=0100 in the EVAL cycle of Req Code=0000 -> CondPass=0 without COND_FLAG_FWD_EN, CondPass=1 with it; Flags=0100 afterwards in both builds.
- Req held high through a taken branch (FLUSH_CYCLES=2) -> second Ack occurs 5 cycles after the first Req edge; no Req is sampled during EVAL or FLUSH.
